// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the loop-controller state table: entry field layout,
// field encodings and the loader state type.
package loop_ctrl_pkg;

   localparam int ENTRY_WIDTH = 47;

   localparam int VALID_LSB  = 0;
   localparam int VALID_W    = 1;
   localparam int LEVEL_LSB  = 1;
   localparam int LEVEL_W    = 2;
   localparam int SC_LSB     = 3;
   localparam int SC_W       = 5;
   localparam int NUM_SC_LSB = 8;
   localparam int NUM_SC_W   = 5;
   localparam int TYPE_LSB   = 13;
   localparam int TYPE_W     = 2;
   localparam int TRIG_LSB   = 15;
   localparam int TRIG_W     = 32;

   typedef enum logic [1:0] {
      TYPE_INIT                = 2'd0,
      TYPE_BODY_AND_CHECK_END  = 2'd1
   } entry_type_e;

   typedef enum logic [1:0] {
      LVL_K = 2'd0,
      LVL_J = 2'd1,
      LVL_I = 2'd2
   } loop_level_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ARMED = 2'd2
   } loader_state_e;

   function automatic logic entry_valid(input logic [ENTRY_WIDTH-1:0] e);
      return e[VALID_LSB];
   endfunction

   function automatic logic [TYPE_W-1:0] entry_type(input logic [ENTRY_WIDTH-1:0] e);
      return e[TYPE_LSB +: TYPE_W];
   endfunction

   function automatic logic [LEVEL_W-1:0] entry_level(input logic [ENTRY_WIDTH-1:0] e);
      return e[LEVEL_LSB +: LEVEL_W];
   endfunction

endpackage

// File: rtl/state_table_ram.sv
// DEPTH x ENTRY_W table storage: one synchronous write port, one asynchronous read port.
module state_table_ram #(
   parameter int ENTRY_W = 47,
   parameter int ADDR_W  = 5
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [ENTRY_W-1:0] rd_data
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   // Contents are not reset; the loader gates reads by its entry count instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/state_table_loader.sv
// Loads a loop program from a valid/ready stream into the state table and serves
// zero-latency reads to the loop FSM; raises table_ready once a program is armed.
module state_table_loader
   import loop_ctrl_pkg::*;
#(
   parameter int ENTRY_W = loop_ctrl_pkg::ENTRY_WIDTH,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_req,
   input  logic [DATA_W-1:0]  s_tdata,
   input  logic               s_tvalid,
   input  logic               s_tlast,
   output logic               s_tready,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [ENTRY_W-1:0] rd_entry,
   input  logic               fsm_done,
   output logic               table_ready,
   output logic [ADDR_W:0]    num_entries,
   output logic               err_overflow
);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   loader_state_e      state_q;
   logic [ADDR_W:0]    num_q;
   logic [ADDR_W:0]    num_d;
   logic               err_q;
   logic               tready_q;
   logic               ready_q;
   logic               beat_hs;
   logic               tbl_full;
   logic               wr_en;
   logic [ENTRY_W-1:0] ram_rd_data;
   logic               unused_tdata;

   assign beat_hs      = s_tvalid && tready_q;
   // The count only reaches bit ADDR_W when all DEPTH slots are used.
   assign tbl_full     = num_q[ADDR_W];
   assign wr_en        = beat_hs && !tbl_full;
   assign unused_tdata = ^s_tdata[DATA_W-1:ENTRY_W];

   // Next entry count for an accepted, non-dropped beat.
   always_comb begin
      num_d = num_q;
      if (wr_en) begin
         num_d = num_q + CNT_ONE;
      end else begin
         num_d = num_q;
      end
   end

   // Loader FSM with its registered handshake, status and count outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         num_q    <= '0;
         err_q    <= 1'b0;
         tready_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_req) begin
                  state_q  <= ST_LOAD;
                  num_q    <= '0;
                  err_q    <= 1'b0;
                  tready_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (beat_hs) begin
                  num_q <= num_d;
                  if (tbl_full) begin
                     err_q <= 1'b1;
                  end
                  if (s_tlast) begin
                     state_q  <= ST_ARMED;
                     tready_q <= 1'b0;
                     ready_q  <= 1'b1;
                  end
               end
            end
            ST_ARMED: begin
               if (fsm_done) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               tready_q <= 1'b0;
               ready_q  <= 1'b0;
            end
         endcase
      end
   end

   state_table_ram #(
      .ENTRY_W (ENTRY_W),
      .ADDR_W  (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (num_q[ADDR_W-1:0]),
      .wr_data (s_tdata[ENTRY_W-1:0]),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   // Past the program end the FSM must see an all-zero (invalid) entry.
   assign rd_entry = ((state_q != ST_LOAD) && ({1'b0, rd_addr} < num_q)) ?
                     ram_rd_data : {ENTRY_W{1'b0}};

   assign s_tready     = tready_q;
   assign table_ready  = ready_q;
   assign num_entries  = num_q;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_state_table_loader.sv
// Randomised scoreboard bench for state_table_loader against a queue-based program model.
module tb_state_table_loader;
   localparam int ENTRY_W = 47;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 64;
   localparam int DEPTH   = 32;

   localparam int K_RD = 0;
   localparam int K_TR = 1;
   localparam int K_ST = 2;
   localparam int K_NE = 3;
   localparam int K_EO = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               load_req;
   logic [DATA_W-1:0]  s_tdata;
   logic               s_tvalid;
   logic               s_tlast;
   logic               s_tready;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ENTRY_W-1:0] rd_entry;
   logic               fsm_done;
   logic               table_ready;
   logic [ADDR_W:0]    num_entries;
   logic               err_overflow;

   typedef struct {
      int          kind;
      logic [63:0] exp;
      string       nm;
   } chk_t;

   chk_t sb[$];
   event probe_ev;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: the program is just a list of accepted entries.
   bit                 m_loading = 1'b0;
   bit                 m_armed   = 1'b0;
   bit                 m_err     = 1'b0;
   logic [ENTRY_W-1:0] m_tbl[$];

   state_table_loader #(.ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_req     (load_req),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready),
      .rd_addr      (rd_addr),
      .rd_entry     (rd_entry),
      .fsm_done     (fsm_done),
      .table_ready  (table_ready),
      .num_entries  (num_entries),
      .err_overflow (err_overflow)
   );

   always #20 clk = ~clk;

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // Monitor: each probe event compares every pending expectation with the DUT.
   always @(probe_ev) begin
      while (sb.size() > 0) begin
         chk_t        c;
         logic [63:0] act;
         c = sb.pop_front();
         case (c.kind)
            K_RD:    act = 64'(rd_entry);
            K_TR:    act = 64'(table_ready);
            K_ST:    act = 64'(s_tready);
            K_NE:    act = 64'(num_entries);
            K_EO:    act = 64'(err_overflow);
            default: act = 64'hDEAD;
         endcase
         n_tests++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", c.nm, act, c.exp);
         end
      end
   end

   function automatic logic [63:0] exp_rd(input int a);
      if (m_loading || a >= m_tbl.size()) return 64'd0;
      return 64'(m_tbl[a]);
   endfunction

   task automatic push(input int kind, input logic [63:0] exp, input string nm);
      sb.push_back('{kind, exp, nm});
   endtask

   task automatic fire();
      #1;
      -> probe_ev;
      #1;
   endtask

   task automatic check_rd(input int a, input string nm);
      rd_addr = 5'(a);
      push(K_RD, exp_rd(a), nm);
      fire();
   endtask

   task automatic check_all(input int a, input string nm);
      rd_addr = 5'(a);
      push(K_RD, exp_rd(a), {nm, "_rd"});
      push(K_TR, 64'(m_armed), {nm, "_table_ready"});
      push(K_ST, 64'(m_loading), {nm, "_s_tready"});
      push(K_NE, 64'(m_tbl.size()), {nm, "_num_entries"});
      push(K_EO, 64'(m_err), {nm, "_err_overflow"});
      fire();
   endtask

   // Advance one clock, updating the model from the inputs seen at this edge.
   task automatic step();
      if (rst) begin
         m_loading = 1'b0;
         m_armed   = 1'b0;
         m_err     = 1'b0;
         m_tbl.delete();
      end else if (m_loading) begin
         if (s_tvalid) begin
            if (m_tbl.size() < DEPTH) m_tbl.push_back(s_tdata[ENTRY_W-1:0]);
            else m_err = 1'b1;
            if (s_tlast) begin
               m_loading = 1'b0;
               m_armed   = 1'b1;
            end
         end
      end else if (m_armed) begin
         if (fsm_done) m_armed = 1'b0;
      end else if (load_req) begin
         m_loading = 1'b1;
         m_err     = 1'b0;
         m_tbl.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input bit last);
      s_tdata  = d;
      s_tvalid = 1'b1;
      s_tlast  = last;
      step();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = {$urandom, $urandom};
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
   endtask

   task automatic pulse_done();
      fsm_done = 1'b1;
      step();
      fsm_done = 1'b0;
   endtask

   logic [63:0] vals[3];
   logic [63:0] d32;
   logic [63:0] d;

   initial begin
      vals[0] = 64'h1;
      vals[1] = 64'h2003;
      vals[2] = 64'h7FFF_FFFF_8001;
      rst = 1'b1; load_req = 1'b0; s_tdata = 64'd0; s_tvalid = 1'b0;
      s_tlast = 1'b0; rd_addr = 5'd0; fsm_done = 1'b0;

      // 1: reset state
      step(); step();
      rst = 1'b0;
      check_all(0, "s1_reset");

      // 2: three-entry program
      pulse_load();
      check_all(0, "s2_load");
      for (int i = 0; i < 3; i++) beat(vals[i], i == 2);
      check_all(3, "s2_armed");
      n_tests++;
      if (table_ready !== 1'b1 || num_entries !== 6'd3) begin
         n_fail++;
         $display("FAIL s2_direct: actual tr=%0b ne=%0d required tr=1 ne=3", table_ready, num_entries);
      end
      for (int i = 0; i < 3; i++) begin
         check_rd(i, "s2_rd_model");
         push(K_RD, vals[i], "s2_rd_const");
         fire();
      end

      // 3: gapped valid and dirty upper bits
      pulse_done();
      pulse_load();
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b0;
         step();
         beat(vals[i] | 64'hFFFF_8000_0000_0000, i == 2);
      end
      check_all(2, "s3_armed");
      for (int i = 0; i < 3; i++) begin
         rd_addr = 5'(i);
         push(K_RD, vals[i], "s3_rd_const");
         fire();
      end
      rd_addr = 5'd2;
      #1;
      n_tests++;
      if (64'(rd_entry) !== vals[2]) begin
         n_fail++;
         $display("FAIL s3_direct_rd2: actual %0h required %0h", rd_entry, vals[2]);
      end

      // 4: overflow by one beat
      pulse_done();
      pulse_load();
      d32 = 64'd0;
      for (int i = 0; i < 33; i++) begin
         d = {$urandom, $urandom};
         if (i == 31) d32 = d;
         beat(d, i == 32);
      end
      check_all(31, "s4_full");
      rd_addr = 5'd31;
      push(K_RD, 64'(d32[ENTRY_W-1:0]), "s4_tbl31_const");
      push(K_NE, 64'd32, "s4_num_const");
      push(K_EO, 64'd1, "s4_err_const");
      fire();
      n_tests++;
      if (err_overflow !== 1'b1 || num_entries !== 6'd32 || rd_entry !== d32[ENTRY_W-1:0]) begin
         n_fail++;
         $display("FAIL s4_direct: actual eo=%0b ne=%0d rd=%0h required eo=1 ne=32 rd=%0h",
                  err_overflow, num_entries, rd_entry, d32[ENTRY_W-1:0]);
      end

      // 5: load_req ignored while armed, done returns to idle, reads gated in load
      pulse_load();
      check_all(1, "s5_ignored_load");
      pulse_done();
      check_all(1, "s5_idle");
      push(K_TR, 64'd0, "s5_tr_const");
      fire();
      n_tests++;
      if (table_ready !== 1'b0 || s_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL s5_direct_idle: actual tr=%0b st=%0b required tr=0 st=0", table_ready, s_tready);
      end
      pulse_load();
      check_all(1, "s5_reload");
      push(K_RD, 64'd0, "s5_rd_zero_const");
      fire();

      // 6: reset mid-load
      beat({$urandom, $urandom}, 1'b0);
      beat({$urandom, $urandom}, 1'b0);
      check_all(0, "s6_two_beats");
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all(0, "s6_after_rst");
      n_tests++;
      if (num_entries !== 6'd0 || rd_entry !== {ENTRY_W{1'b0}} || err_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL s6_direct: actual ne=%0d rd=%0h eo=%0b required 0 0 0",
                  num_entries, rd_entry, err_overflow);
      end

      // Random programs with gaps, spurious control pulses and occasional reset
      for (int p = 0; p < 12; p++) begin
         int  len;
         bit  aborted;
         len = $urandom_range(1, 36);
         aborted = 1'b0;
         fsm_done = 1'($urandom_range(0, 1));
         step();
         fsm_done = 1'b0;
         check_all($urandom_range(0, 31), "rnd_idle");
         pulse_load();
         for (int b = 0; b < len; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               fsm_done = 1'($urandom_range(0, 1));
               load_req = 1'($urandom_range(0, 1));
               step();
               fsm_done = 1'b0;
               load_req = 1'b0;
               check_all($urandom_range(0, 31), "rnd_gap");
            end
            if ($urandom_range(0, 39) == 0) begin
               rst = 1'b1;
               step();
               rst = 1'b0;
               check_all($urandom_range(0, 31), "rnd_rst");
               aborted = 1'b1;
               break;
            end
            beat({$urandom, $urandom}, b == len - 1);
         end
         if (!aborted) begin
            for (int r = 0; r < 4; r++) begin
               load_req = 1'($urandom_range(0, 1));
               step();
               load_req = 1'b0;
               check_all($urandom_range(0, 31), "rnd_armed");
            end
            pulse_done();
            check_all($urandom_range(0, 31), "rnd_done");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      if (n_fail != 0 || n_tests < 12) begin
         $display("FAIL summary: %0d failures in %0d tests", n_fail, n_tests);
      end else begin
         $display("PASS");
      end
      $finish;
   end

endmodule
